// File: rtl/dcache_port_arbiter_pkg.sv
// Shared constants and FSM encoding for the dcache port arbiter and its read-ID FIFO.
package dcache_arb_pkg;
    localparam int DEF_NR_PORTS        = 3;
    localparam int DEF_PAYLOAD_W       = 76;
    localparam int DEF_XLEN            = 32;
    localparam int DEF_MAX_OUTSTANDING = 2;

    localparam int ID_W  = $clog2(DEF_NR_PORTS);
    localparam int CNT_W = $clog2(DEF_MAX_OUTSTANDING) + 1;

    typedef logic [0:0] state_t;
    localparam state_t IDLE   = 1'b0;
    localparam state_t LOCKED = 1'b1;
endpackage

// File: rtl/dcache_port_arbiter_if.sv
// Requester-side and dcache-side signals of the port arbiter; slave is the arbiter's view.
interface dcache_port_arbiter_if
    import dcache_arb_pkg::*;
#(
    parameter int NR_PORTS  = DEF_NR_PORTS,
    parameter int PAYLOAD_W = DEF_PAYLOAD_W,
    parameter int XLEN      = DEF_XLEN
);
    logic [NR_PORTS-1:0]           req_i;
    logic [NR_PORTS-1:0]           we_i;
    logic [NR_PORTS*PAYLOAD_W-1:0] payload_i;
    logic [NR_PORTS-1:0]           gnt_o;
    logic [NR_PORTS-1:0]           rvalid_o;
    logic [XLEN-1:0]               rdata_o;
    logic                          req_o;
    logic                          we_o;
    logic [PAYLOAD_W-1:0]          payload_o;
    logic                          gnt_i;
    logic                          rvalid_i;
    logic [XLEN-1:0]               rdata_i;
    logic                          err_o;

    modport slave (
        input  req_i, we_i, payload_i, gnt_i, rvalid_i, rdata_i,
        output gnt_o, rvalid_o, rdata_o, req_o, we_o, payload_o, err_o
    );

    modport master (
        output req_i, we_i, payload_i, gnt_i, rvalid_i, rdata_i,
        input  gnt_o, rvalid_o, rdata_o, req_o, we_o, payload_o, err_o
    );
endinterface

// File: rtl/dcache_port_arbiter_id_fifo.sv
// In-order FIFO of requester IDs for reads still awaiting a dcache response.
module dcache_arb_id_fifo
    import dcache_arb_pkg::*;
#(
    parameter int DEPTH = DEF_MAX_OUTSTANDING,
    parameter int WIDTH = ID_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] count;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == OCC_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares one dcache request port between LSU requesters and routes read responses back in order.
// DCACHE_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins) instead of round-robin.
//
// state  | meaning
// IDLE   | scanning requesters; grant may complete in the same cycle
// LOCKED | dcache stalled; selection frozen until gnt_i
module dcache_port_arbiter
    import dcache_arb_pkg::*;
#(
    parameter int NR_PORTS        = DEF_NR_PORTS,
    parameter int PAYLOAD_W       = DEF_PAYLOAD_W,
    parameter int XLEN            = DEF_XLEN,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    dcache_port_arbiter_if.slave bus
);
    localparam int SEL_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    state_t              state_q;
    logic [SEL_W-1:0]    sel_q;
    logic [SEL_W-1:0]    sel_scan;
    logic [SEL_W-1:0]    sel;
    logic [SEL_W-1:0]    head_id;
    logic [NR_PORTS-1:0] elig;
    logic                any_elig;
    logic                grant;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic                err_q;
    int                  start_idx;

`ifdef DCACHE_ARB_FIXED_PRIO_EN
    assign start_idx = 0;
`else
    logic [SEL_W-1:0] rr_ptr_q;

    assign start_idx = int'(rr_ptr_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (grant) begin
            rr_ptr_q <= (sel == SEL_W'(NR_PORTS - 1)) ? '0 : sel + 1'b1;
        end
    end
`endif

    // Full check uses the registered occupancy, so a same-cycle pop never frees a slot.
    assign elig = bus.req_i & (bus.we_i | {NR_PORTS{~fifo_full}});

    always_comb begin
        int               idx;
        logic [SEL_W-1:0] cand;
        sel_scan = '0;
        any_elig = 1'b0;
        idx      = 0;
        cand     = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            idx  = (start_idx + i) % NR_PORTS;
            cand = SEL_W'(idx);
            if (!any_elig && elig[cand]) begin
                any_elig = 1'b1;
                sel_scan = cand;
            end
        end
    end

    assign sel = (state_q == LOCKED) ? sel_q : sel_scan;

    // Gating with rst_ni keeps the dcache-side outputs quiet the instant reset asserts.
    assign bus.req_o     = rst_ni && ((state_q == LOCKED) || any_elig);
    assign bus.we_o      = bus.req_o && bus.we_i[sel];
    assign bus.payload_o = bus.payload_i[int'(sel)*PAYLOAD_W +: PAYLOAD_W];

    assign grant     = bus.req_o && bus.gnt_i;
    assign bus.gnt_o = grant ? (NR_PORTS'(1) << sel) : '0;

    assign push         = grant && !bus.we_o;
    assign pop          = bus.rvalid_i && !fifo_empty;
    assign bus.rvalid_o = pop ? (NR_PORTS'(1) << head_id) : '0;
    assign bus.rdata_o  = bus.rdata_i;
    assign bus.err_o    = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_elig && !bus.gnt_i) begin
                        state_q <= LOCKED;
                        sel_q   <= sel_scan;
                    end
                end
                LOCKED: begin
                    if (bus.gnt_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (bus.rvalid_i && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

    dcache_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (SEL_W)
    ) u_id_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .pop    (pop),
        .din    (sel),
        .head   (head_id),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed-vector bench for dcache_port_arbiter with hand-computed expectations.
module tb_dcache_port_arbiter;
    import dcache_arb_pkg::*;

    localparam logic [75:0] PL0 = 76'h0_1111_2222_3333_4444;
    localparam logic [75:0] PL1 = 76'h5_AAAA_BBBB_CCCC_DDDD;
    localparam logic [75:0] PL2 = 76'h9_0F0F_F0F0_1234_5678;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   n_vec  = 0;
    int   n_bad  = 0;

    always #5 clk_i = ~clk_i;

    dcache_port_arbiter_if #(.NR_PORTS(3), .PAYLOAD_W(76), .XLEN(32)) bus ();

    dcache_port_arbiter #(
        .NR_PORTS        (3),
        .PAYLOAD_W       (76),
        .XLEN            (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp_v);
        n_vec++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
        end
    endtask

    task automatic drive(input logic [2:0] req, input logic [2:0] we, input logic gnt,
                         input logic rv, input logic [31:0] rd);
        bus.req_i    = req;
        bus.we_i     = we;
        bus.gnt_i    = gnt;
        bus.rvalid_i = rv;
        bus.rdata_i  = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        drive(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        rst_ni = 1'b1;
        tick();
    endtask

    logic [2:0] fair_exp [4];

    initial begin
`ifdef DCACHE_ARB_FIXED_PRIO_EN
        fair_exp = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
        fair_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif
        bus.payload_i = {PL2, PL1, PL0};
        drive(3'b111, 3'b111, 1'b1, 1'b1, 32'h0);
        #10;
        chk("rst_req_o", bus.req_o, 1'b0);
        chk("rst_we_o", bus.we_o, 1'b0);
        chk("rst_gnt_o", bus.gnt_o, 3'b000);
        chk("rst_rvalid_o", bus.rvalid_o, 3'b000);
        chk("rst_err_o", bus.err_o, 1'b0);
        do_reset();

        // single read on port 1, granted at once, response two cycles later
        drive(3'b010, 3'b000, 1'b1, 1'b0, 32'h0);
        chk("rd1_req_o", bus.req_o, 1'b1);
        chk("rd1_we_o", bus.we_o, 1'b0);
        chk("rd1_payload", bus.payload_o, PL1);
        chk("rd1_gnt", bus.gnt_o, 3'b010);
        tick();
        drive(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        chk("rd1_idle_rvalid", bus.rvalid_o, 3'b000);
        tick();
        drive(3'b000, 3'b000, 1'b0, 1'b1, 32'hDEADBEEF);
        chk("rd1_rvalid", bus.rvalid_o, 3'b010);
        chk("rd1_rdata", bus.rdata_o, 32'hDEADBEEF);
        tick();
        drive(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        chk("rd1_err", bus.err_o, 1'b0);
        do_reset();

        // fairness: three writers, dcache always ready
        for (int i = 0; i < 4; i++) begin
            drive(3'b111, 3'b111, 1'b1, 1'b0, 32'h0);
            chk($sformatf("fair_gnt%0d", i), bus.gnt_o, fair_exp[i]);
            chk($sformatf("fair_we%0d", i), bus.we_o, 1'b1);
            tick();
        end
        do_reset();

        // hold under stall, then in-order routing of reads from ports 2 and 0
        drive(3'b100, 3'b000, 1'b0, 1'b0, 32'h0);
        chk("hold_req0", bus.req_o, 1'b1);
        chk("hold_pl0", bus.payload_o, PL2);
        chk("hold_gnt0", bus.gnt_o, 3'b000);
        tick();
        for (int i = 1; i < 3; i++) begin
            drive(3'b101, 3'b000, 1'b0, 1'b0, 32'h0);
            chk($sformatf("hold_pl%0d", i), bus.payload_o, PL2);
            chk($sformatf("hold_gnt%0d", i), bus.gnt_o, 3'b000);
            tick();
        end
        drive(3'b101, 3'b000, 1'b1, 1'b0, 32'h0);
        chk("hold_pl3", bus.payload_o, PL2);
        chk("hold_gnt3", bus.gnt_o, 3'b100);
        tick();
        drive(3'b001, 3'b000, 1'b1, 1'b0, 32'h0);
        chk("ord_gnt_p0", bus.gnt_o, 3'b001);
        tick();
        drive(3'b000, 3'b000, 1'b0, 1'b1, 32'h1234_5678);
        chk("ord_rvalid_a", bus.rvalid_o, 3'b100);
        chk("ord_rdata_a", bus.rdata_o, 32'h1234_5678);
        tick();
        drive(3'b000, 3'b000, 1'b0, 1'b1, 32'h0000_0009);
        chk("ord_rvalid_b", bus.rvalid_o, 3'b001);
        tick();
        drive(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        chk("ord_err", bus.err_o, 1'b0);
        do_reset();

        // FIFO full: reads back-pressured, writes still pass
        drive(3'b001, 3'b000, 1'b1, 1'b0, 32'h0);
        chk("full_gnt_p0", bus.gnt_o, 3'b001);
        tick();
        drive(3'b010, 3'b000, 1'b1, 1'b0, 32'h0);
        chk("full_gnt_p1", bus.gnt_o, 3'b010);
        tick();
        drive(3'b100, 3'b000, 1'b1, 1'b0, 32'h0);
        chk("full_req_o", bus.req_o, 1'b0);
        chk("full_gnt_none", bus.gnt_o, 3'b000);
        tick();
        drive(3'b110, 3'b010, 1'b1, 1'b0, 32'h0);
        chk("full_wr_gnt", bus.gnt_o, 3'b010);
        chk("full_wr_we", bus.we_o, 1'b1);
        chk("full_wr_pl", bus.payload_o, PL1);
        tick();
        drive(3'b100, 3'b000, 1'b1, 1'b1, 32'h0000_00A5);
        chk("full_pop_req_o", bus.req_o, 1'b0);
        chk("full_pop_gnt", bus.gnt_o, 3'b000);
        chk("full_pop_rvalid", bus.rvalid_o, 3'b001);
        tick();
        drive(3'b100, 3'b000, 1'b1, 1'b0, 32'h0);
        chk("full_p2_gnt", bus.gnt_o, 3'b100);
        tick();
        drive(3'b000, 3'b000, 1'b0, 1'b1, 32'h0);
        chk("drain_rvalid_p1", bus.rvalid_o, 3'b010);
        tick();
        drive(3'b001, 3'b000, 1'b1, 1'b1, 32'h0);
        chk("pushpop_gnt", bus.gnt_o, 3'b001);
        chk("pushpop_rvalid", bus.rvalid_o, 3'b100);
        tick();
        drive(3'b000, 3'b000, 1'b0, 1'b1, 32'h0);
        chk("pushpop_next", bus.rvalid_o, 3'b001);
        tick();

        // response with empty FIFO sets sticky error
        drive(3'b000, 3'b000, 1'b0, 1'b1, 32'h0);
        chk("err_rvalid", bus.rvalid_o, 3'b000);
        chk("err_before", bus.err_o, 1'b0);
        tick();
        drive(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        chk("err_set", bus.err_o, 1'b1);
        tick();
        drive(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        chk("err_held", bus.err_o, 1'b1);
        tick();

        // asynchronous reset while LOCKED
        drive(3'b010, 3'b010, 1'b0, 1'b0, 32'h0);
        chk("lock_req_o", bus.req_o, 1'b1);
        tick();
        drive(3'b010, 3'b010, 1'b1, 1'b0, 32'h0);
        rst_ni = 1'b0;
        #1;
        chk("arst_req_o", bus.req_o, 1'b0);
        chk("arst_gnt_o", bus.gnt_o, 3'b000);
        chk("arst_err_o", bus.err_o, 1'b0);
        rst_ni = 1'b1;
        #1;
        chk("arst_release_gnt", bus.gnt_o, 3'b010);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
